// File: rtl/snn_acc_sequencer_if.sv
// Handshake and A-bus bundle between instruction decode / VLSU and the
// spike-accumulate sequencer. The sequencer is the slave side.
interface snn_acc_sequencer_if;
  // Command channel from instruction decode
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_op;
  logic [4:0] cmd_wbase;
  logic [4:0] cmd_sbase;
  logic [4:0] cmd_nbase;
  logic [3:0] cmd_count;

  // VLSU register-load channel
  logic       ld_valid;
  logic       ld_ready;
  logic [1:0] ld_tgt;
  logic [7:0] ld_a;

  logic       abort;

  // Register-bank A buses and status
  logic [7:0] wvr_a;
  logic [7:0] svr_a;
  logic [7:0] nsr_a;
  logic       nsr_dsel;
  logic       busy;
  logic       done;
  logic       err;

  modport slave (
    input  cmd_valid, cmd_op, cmd_wbase, cmd_sbase, cmd_nbase, cmd_count,
    input  ld_valid, ld_tgt, ld_a, abort,
    output cmd_ready, ld_ready,
    output wvr_a, svr_a, nsr_a, nsr_dsel, busy, done, err
  );

  modport master (
    output cmd_valid, cmd_op, cmd_wbase, cmd_sbase, cmd_nbase, cmd_count,
    output ld_valid, ld_tgt, ld_a, abort,
    input  cmd_ready, ld_ready,
    input  wvr_a, svr_a, nsr_a, nsr_dsel, busy, done, err
  );
endinterface

// File: rtl/snn_acc_sequencer.sv
// Drives the WVR/SVR/NSR A buses through FETCH -> WAIT -> WB steps for
// convh/doth and conva/dota, and forwards VLSU loads while idle.
module snn_acc_sequencer #(
  parameter int unsigned SACC_LAT = 1,
  parameter logic [7:0]  IDLE_A   = 8'hE0
) (
  input  logic                 clk,
  input  logic                 reset,
  snn_acc_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    WB    = 2'd3
  } state_t;

  localparam logic [2:0] FUNCT_H   = 3'b011;
  localparam logic [2:0] FUNCT_A   = 3'b100;
  localparam logic [3:0] WAIT_INIT = 4'(SACC_LAT - 1);

  state_t     state_q,    state_d;
  logic       op_q,       op_d;
  logic [3:0] wbase_q,    wbase_d;
  logic [3:0] sbase_q,    sbase_d;
  logic [3:0] nbase_q,    nbase_d;
  logic [3:0] cnt_q,      cnt_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic [7:0] wvr_a_q,    wvr_a_d;
  logic [7:0] svr_a_q,    svr_a_d;
  logic [7:0] nsr_a_q,    nsr_a_d;
  logic       nsr_dsel_q, nsr_dsel_d;
  logic       done_q,     done_d;
  logic       err_q,      err_d;

  // Bases are tracked mod 16, so bit 4 of the command bases never matters.
  logic unused_base_msbs;
  assign unused_base_msbs = ^{bus.cmd_wbase[4], bus.cmd_sbase[4], bus.cmd_nbase[4]};

  // conva/dota addresses WVR and NSR through a fixed accumulator slot 0.
  function automatic logic [7:0] wn_word(input logic op, input logic [3:0] base);
    return op ? {FUNCT_A, 5'd0} : {FUNCT_H, 1'b0, base};
  endfunction

  function automatic logic [7:0] s_word(input logic op, input logic [3:0] base);
    return op ? {FUNCT_A, 1'b0, base} : {FUNCT_H, 1'b0, base};
  endfunction

  assign bus.ld_ready  = (state_q == IDLE);
  assign bus.cmd_ready = (state_q == IDLE) && !bus.ld_valid;
  assign bus.busy      = (state_q != IDLE);
  assign bus.wvr_a     = wvr_a_q;
  assign bus.svr_a     = svr_a_q;
  assign bus.nsr_a     = nsr_a_q;
  assign bus.nsr_dsel  = nsr_dsel_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    wbase_d    = wbase_q;
    sbase_d    = sbase_q;
    nbase_d    = nbase_q;
    cnt_d      = cnt_q;
    wait_cnt_d = wait_cnt_q;
    wvr_a_d    = IDLE_A;
    svr_a_d    = IDLE_A;
    nsr_a_d    = IDLE_A;
    nsr_dsel_d = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.ld_valid) begin
          case (bus.ld_tgt)
            2'd0:    wvr_a_d = bus.ld_a;
            2'd1:    svr_a_d = bus.ld_a;
            2'd2:    nsr_a_d = bus.ld_a;
            default: err_d   = 1'b1;
          endcase
        end else if (bus.cmd_valid) begin
          op_d    = bus.cmd_op;
          wbase_d = bus.cmd_wbase[3:0];
          sbase_d = bus.cmd_sbase[3:0];
          nbase_d = bus.cmd_nbase[3:0];
          cnt_d   = bus.cmd_count;
          if (bus.cmd_count == 4'd0) begin
            err_d = 1'b1;
          end else begin
            state_d = FETCH;
          end
        end
      end

      FETCH: begin
        state_d    = WAIT;
        wait_cnt_d = WAIT_INIT;
      end

      WAIT: begin
        if (wait_cnt_q == 4'd0) begin
          state_d    = WB;
          nsr_a_d    = wn_word(op_q, nbase_q);
          nsr_dsel_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end

      WB: begin
        if (op_q) begin
          sbase_d = sbase_q + 4'd4;
        end else begin
          wbase_d = wbase_q + 4'd4;
          sbase_d = sbase_q + 4'd1;
          nbase_d = nbase_q + 4'd4;
        end
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = FETCH;
        end
      end

      default: state_d = IDLE;
    endcase

    // The WB word already on the bus this cycle is left to finish.
    if (bus.abort && (state_q != IDLE)) begin
      state_d    = IDLE;
      nsr_a_d    = IDLE_A;
      nsr_dsel_d = 1'b0;
      done_d     = 1'b0;
    end

    // Fetch words come from the bases the FETCH step will actually use.
    if (state_d == FETCH) begin
      wvr_a_d = wn_word(op_d, wbase_d);
      svr_a_d = s_word(op_d, sbase_d);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      op_q       <= 1'b0;
      wbase_q    <= 4'd0;
      sbase_q    <= 4'd0;
      nbase_q    <= 4'd0;
      cnt_q      <= 4'd0;
      wait_cnt_q <= 4'd0;
      wvr_a_q    <= IDLE_A;
      svr_a_q    <= IDLE_A;
      nsr_a_q    <= IDLE_A;
      nsr_dsel_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      wbase_q    <= wbase_d;
      sbase_q    <= sbase_d;
      nbase_q    <= nbase_d;
      cnt_q      <= cnt_d;
      wait_cnt_q <= wait_cnt_d;
      wvr_a_q    <= wvr_a_d;
      svr_a_q    <= svr_a_d;
      nsr_a_q    <= nsr_a_d;
      nsr_dsel_q <= nsr_dsel_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_snn_acc_sequencer.sv
// Scoreboard bench: stimulus pushes hand-computed bus events with their cycle,
// a negedge monitor pops and compares every non-idle output cycle.
module tb_snn_acc_sequencer;
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   vectors = 0;
  int   fails = 0;
  bit   mon_en = 1'b0;

  snn_acc_sequencer_if sif ();

  snn_acc_sequencer #(.SACC_LAT(1), .IDLE_A(8'hE0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [7:0] w;
    logic [7:0] s;
    logic [7:0] n;
    logic       dsel;
    logic       done;
    logic       err;
  } exp_t;

  exp_t sb[$];

  task automatic push(input int c, input logic [7:0] w, input logic [7:0] s,
                      input logic [7:0] n, input logic dsel, input logic done,
                      input logic err);
    exp_t e;
    e.cyc = c; e.w = w; e.s = s; e.n = n; e.dsel = dsel; e.done = done; e.err = err;
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic op, input logic [4:0] w, input logic [4:0] s,
                          input logic [4:0] n, input logic [3:0] cnt, output int c);
    sif.cmd_op    = op;
    sif.cmd_wbase = w;
    sif.cmd_sbase = s;
    sif.cmd_nbase = n;
    sif.cmd_count = cnt;
    sif.cmd_valid = 1'b1;
    c = cyc;
    #1;
    chk("cmd_ready_at_issue", 32'(sif.cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    sif.cmd_valid = 1'b0;
  endtask

  // Monitor: any cycle with a non-idle output is one transaction.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
          vectors++;
          fails++;
          $display("FAIL missed_event: got nothing at cycle %0d, want w=%h s=%h n=%h dsel=%b done=%b err=%b",
                   sb[0].cyc, sb[0].w, sb[0].s, sb[0].n, sb[0].dsel, sb[0].done, sb[0].err);
          void'(sb.pop_front());
        end
        if (sif.wvr_a != 8'hE0 || sif.svr_a != 8'hE0 || sif.nsr_a != 8'hE0 ||
            sif.nsr_dsel || sif.done || sif.err) begin
          vectors++;
          $display("ev cyc=%0d w=%h s=%h n=%h dsel=%b done=%b err=%b",
                   cyc, sif.wvr_a, sif.svr_a, sif.nsr_a, sif.nsr_dsel, sif.done, sif.err);
          if (sb.size() == 0 || sb[0].cyc != cyc) begin
            fails++;
            $display("FAIL unexpected_event: got activity at cycle %0d, want idle buses", cyc);
          end else begin
            exp_t e;
            e = sb.pop_front();
            if (e.w !== sif.wvr_a || e.s !== sif.svr_a || e.n !== sif.nsr_a ||
                e.dsel !== sif.nsr_dsel || e.done !== sif.done || e.err !== sif.err) begin
              fails++;
              $display("FAIL bus_event@%0d: got w=%h s=%h n=%h dsel=%b done=%b err=%b, want w=%h s=%h n=%h dsel=%b done=%b err=%b",
                       cyc, sif.wvr_a, sif.svr_a, sif.nsr_a, sif.nsr_dsel, sif.done, sif.err,
                       e.w, e.s, e.n, e.dsel, e.done, e.err);
            end
          end
        end
      end
    end
  end

  initial begin
    int c;
    sif.cmd_valid = 1'b0; sif.cmd_op = 1'b0;
    sif.cmd_wbase = '0; sif.cmd_sbase = '0; sif.cmd_nbase = '0; sif.cmd_count = '0;
    sif.ld_valid = 1'b0; sif.ld_tgt = '0; sif.ld_a = '0; sif.abort = 1'b0;
    reset = 1'b1;
    #2 reset = 1'b0;
    #10;
    chk("rst_wvr_a", 32'(sif.wvr_a), 32'hE0);
    chk("rst_svr_a", 32'(sif.svr_a), 32'hE0);
    chk("rst_nsr_a", 32'(sif.nsr_a), 32'hE0);
    chk("rst_busy",  32'(sif.busy),  32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    mon_en = 1'b1;
    step(2);
    chk("idle_cmd_ready", 32'(sif.cmd_ready), 32'd1);
    chk("idle_ld_ready",  32'(sif.ld_ready),  32'd1);
    chk("idle_busy",      32'(sif.busy),      32'd0);
    chk("idle_done",      32'(sif.done),      32'd0);
    chk("idle_err",       32'(sif.err),       32'd0);
    chk("idle_nsr_dsel",  32'(sif.nsr_dsel),  32'd0);

    // op 0, wbase 2, sbase 5, nbase 14, two steps; nbase wraps to 2
    send_cmd(1'b0, 5'd2, 5'd5, 5'd14, 4'd2, c);
    push(c + 1, 8'h62, 8'h65, 8'hE0, 1'b0, 1'b0, 1'b0);
    push(c + 3, 8'hE0, 8'hE0, 8'h6E, 1'b1, 1'b0, 1'b0);
    push(c + 4, 8'h66, 8'h66, 8'hE0, 1'b0, 1'b0, 1'b0);
    push(c + 6, 8'hE0, 8'hE0, 8'h62, 1'b1, 1'b0, 1'b0);
    push(c + 7, 8'hE0, 8'hE0, 8'hE0, 1'b0, 1'b1, 1'b0);
    step(1);
    chk("busy_in_cmd", 32'(sif.busy), 32'd1);
    chk("cmd_ready_busy", 32'(sif.cmd_ready), 32'd0);
    step(5);

    // Back-to-back in the done cycle: op 1, sbase 13, three steps
    send_cmd(1'b1, 5'd7, 5'd13, 5'd9, 4'd3, c);
    push(c + 1,  8'h80, 8'h8D, 8'hE0, 1'b0, 1'b0, 1'b0);
    push(c + 3,  8'hE0, 8'hE0, 8'h80, 1'b1, 1'b0, 1'b0);
    push(c + 4,  8'h80, 8'h81, 8'hE0, 1'b0, 1'b0, 1'b0);
    push(c + 6,  8'hE0, 8'hE0, 8'h80, 1'b1, 1'b0, 1'b0);
    push(c + 7,  8'h80, 8'h85, 8'hE0, 1'b0, 1'b0, 1'b0);
    push(c + 9,  8'hE0, 8'hE0, 8'h80, 1'b1, 1'b0, 1'b0);
    push(c + 10, 8'hE0, 8'hE0, 8'hE0, 1'b0, 1'b1, 1'b0);
    step(11);

    // Loads to WVR then SVR on consecutive cycles
    sif.ld_valid = 1'b1; sif.ld_tgt = 2'd0; sif.ld_a = 8'h35;
    c = cyc;
    push(c + 1, 8'h35, 8'hE0, 8'hE0, 1'b0, 1'b0, 1'b0);
    step(1);
    sif.ld_tgt = 2'd1; sif.ld_a = 8'h4A;
    push(c + 2, 8'hE0, 8'h4A, 8'hE0, 1'b0, 1'b0, 1'b0);
    step(1);
    sif.ld_valid = 1'b0;
    step(2);

    // Load and command together: load wins, command goes next cycle
    sif.ld_valid = 1'b1; sif.ld_tgt = 2'd2; sif.ld_a = 8'h20;
    sif.cmd_op = 1'b0; sif.cmd_wbase = 5'd0; sif.cmd_sbase = 5'd0;
    sif.cmd_nbase = 5'd0; sif.cmd_count = 4'd1; sif.cmd_valid = 1'b1;
    c = cyc;
    #1;
    chk("collide_cmd_ready", 32'(sif.cmd_ready), 32'd0);
    chk("collide_ld_ready",  32'(sif.ld_ready),  32'd1);
    push(c + 1, 8'hE0, 8'hE0, 8'h20, 1'b0, 1'b0, 1'b0);
    step(1);
    sif.ld_valid = 1'b0;
    #1;
    chk("collide_cmd_ready_next", 32'(sif.cmd_ready), 32'd1);
    push(c + 2, 8'h60, 8'h60, 8'hE0, 1'b0, 1'b0, 1'b0);
    push(c + 4, 8'hE0, 8'hE0, 8'h60, 1'b1, 1'b0, 1'b0);
    push(c + 5, 8'hE0, 8'hE0, 8'hE0, 1'b0, 1'b1, 1'b0);
    step(1);
    sif.cmd_valid = 1'b0;
    step(5);

    // Zero-count command
    send_cmd(1'b0, 5'd1, 5'd1, 5'd1, 4'd0, c);
    push(c + 1, 8'hE0, 8'hE0, 8'hE0, 1'b0, 1'b0, 1'b1);
    chk("count0_busy", 32'(sif.busy), 32'd0);
    step(2);

    // Illegal load target
    sif.ld_valid = 1'b1; sif.ld_tgt = 2'd3; sif.ld_a = 8'h55;
    c = cyc;
    push(c + 1, 8'hE0, 8'hE0, 8'hE0, 1'b0, 1'b0, 1'b1);
    step(1);
    sif.ld_valid = 1'b0;
    chk("ldtgt3_busy", 32'(sif.busy), 32'd0);
    step(2);

    // Abort while idle does nothing
    sif.abort = 1'b1;
    step(1);
    sif.abort = 1'b0;
    chk("abort_idle_busy", 32'(sif.busy), 32'd0);
    step(1);

    // Abort during WAIT of step 1 of 3
    send_cmd(1'b0, 5'd1, 5'd1, 5'd1, 4'd3, c);
    push(c + 1, 8'h61, 8'h61, 8'hE0, 1'b0, 1'b0, 1'b0);
    step(1);
    sif.abort = 1'b1;
    step(1);
    sif.abort = 1'b0;
    chk("abort_wait_busy", 32'(sif.busy), 32'd0);
    chk("abort_wait_cmd_ready", 32'(sif.cmd_ready), 32'd1);
    step(12);

    // Abort in WB: that WB word still appears, then nothing
    send_cmd(1'b0, 5'd3, 5'd3, 5'd3, 4'd2, c);
    push(c + 1, 8'h63, 8'h63, 8'hE0, 1'b0, 1'b0, 1'b0);
    push(c + 3, 8'hE0, 8'hE0, 8'h63, 1'b1, 1'b0, 1'b0);
    step(2);
    sif.abort = 1'b1;
    step(1);
    sif.abort = 1'b0;
    chk("abort_wb_busy", 32'(sif.busy), 32'd0);
    step(10);

    // Async reset while in FETCH
    send_cmd(1'b0, 5'd4, 5'd4, 5'd4, 4'd1, c);
    reset = 1'b0;
    #1;
    chk("arst_wvr_a", 32'(sif.wvr_a), 32'hE0);
    chk("arst_svr_a", 32'(sif.svr_a), 32'hE0);
    chk("arst_busy",  32'(sif.busy),  32'd0);
    step(2);
    reset = 1'b1;
    step(10);
    chk("post_rst_cmd_ready", 32'(sif.cmd_ready), 32'd1);
    step(3);

    while (sb.size() > 0) begin
      vectors++;
      fails++;
      $display("FAIL pending_event: got nothing, want event at cycle %0d", sb[0].cyc);
      void'(sb.pop_front());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
